// File: rtl/serial_subtractor_pkg.sv
// Shared constants and FSM encoding for the bit-serial subtractor.
// Saturation values are used only when SERIAL_SUBTRACTOR_SATURATE_EN is defined.
package serial_subtractor_pkg;

    localparam int SUB_W = 8;
    localparam int CNT_W = $clog2(SUB_W);

    localparam logic [SUB_W-1:0] SAT_POS = 8'h7F;
    localparam logic [SUB_W-1:0] SAT_NEG = 8'h80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic [SUB_W-1:0] sat_value(input logic sign_a);
        return sign_a ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: a - b - borrow_in.
// Instantiated once by serial_subtractor and reused on every serial step.
module full_subtractor (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_diff,
    output logic o_bout
);

    assign o_diff = i_a ^ i_b ^ i_bin;
    assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial 8-bit two's-complement subtractor, LSB first, 8 cycles per result.
// Define SERIAL_SUBTRACTOR_SATURATE_EN to clamp overflowing results.
module serial_subtractor
    import serial_subtractor_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SUB_W-1:0] in_a,
    input  logic [SUB_W-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [SUB_W:0]   out
);

    state_t           r_state;
    state_t           w_next;
    logic [SUB_W-1:0] r_a;
    logic [SUB_W-1:0] r_b;
    logic [SUB_W-2:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_borrow;
    logic [SUB_W:0]   r_out;

    logic             w_diff;
    logic             w_bout;
    logic             w_last;
    logic             w_ovf;
    logic             w_capture;
    logic [SUB_W-1:0] w_res;
    logic [SUB_W-1:0] w_final;

    full_subtractor u_fs (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_borrow),
        .o_diff (w_diff),
        .o_bout (w_bout)
    );

    assign w_last    = (r_cnt == CNT_W'(SUB_W - 1));
    assign w_res     = {w_diff, r_res};
    assign w_capture = start && (r_state == IDLE || r_state == DONE);

    // On the last step r_a[0]/r_b[0] are the operand sign bits
    assign w_ovf = (r_a[0] ^ r_b[0]) & (w_diff ^ r_a[0]);

`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
    assign w_final = w_ovf ? sat_value(r_a[0]) : w_res;
`else
    assign w_final = w_res;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == SHIFT);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_out    <= '0;
        end else if (w_capture) begin
            r_a      <= in_a;
            r_b      <= in_b;
            r_res    <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
        end else if (r_state == SHIFT) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_res    <= w_res[SUB_W-1:1];
            r_borrow <= w_bout;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_out <= {w_ovf, w_final};
            end
        end
    end

    assign out = r_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, corner sequences,
// and random operands against an arithmetic reference model.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       busy;
    logic       done;
    logic [8:0] out;

    int errs;
    int checks;

    serial_subtractor dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in_a  (in_a),
        .in_b  (in_b),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] e_wrap;
        logic [8:0] e_sat;
    } vec_t;

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [8:0] model(input logic [7:0] a,
                                         input logic [7:0] b);
        int         full;
        logic       ovf;
        logic [7:0] r;
        full = int'($signed(a)) - int'($signed(b));
        ovf  = (full > 127) || (full < -128);
        r    = 8'(full);
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
        if (ovf) r = (full < 0) ? 8'h80 : 8'h7F;
`endif
        return {ovf, r};
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input bit noise, input bit chg,
                          output logic [8:0] res, output int lat,
                          output int bcnt);
        @(negedge clk);
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        bcnt  = busy ? 1 : 0;
        if (chg) begin
            in_a = 8'hFF;
            in_b = 8'hFF;
        end
        while (!done && lat < 20) begin
            if (noise && lat < 7) begin
                start = 1'($urandom);
                in_a  = 8'($urandom);
                in_b  = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
        res   = out;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("done_pulse", int'(done), 0);
        check("out_hold", int'(out), int'(res));
    endtask

    vec_t       tbl[7];
    logic [8:0] res;
    logic [8:0] exp_v;
    int         lat;
    int         bcnt;
    int         n;
    int         dcnt;

    initial begin
        errs   = 0;
        checks = 0;
        tbl[0] = '{8'h05, 8'h03, 9'h002, 9'h002};
        tbl[1] = '{8'h03, 8'h05, 9'h0FE, 9'h0FE};
        tbl[2] = '{8'h00, 8'h00, 9'h000, 9'h000};
        tbl[3] = '{8'h80, 8'h01, 9'h17F, 9'h180};
        tbl[4] = '{8'h7F, 8'hFF, 9'h180, 9'h17F};
        tbl[5] = '{8'h7F, 8'h80, 9'h1FF, 9'h17F};
        tbl[6] = '{8'h80, 8'h7F, 9'h101, 9'h180};

        rst   = 1'b1;
        start = 1'b0;
        in_a  = 8'h00;
        in_b  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_out", int'(out), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
            exp_v = tbl[i].e_sat;
`else
            exp_v = tbl[i].e_wrap;
`endif
            run_op(tbl[i].a, tbl[i].b, 1'b0, 1'b0, res, lat, bcnt);
            check("vec_out", int'(res), int'(exp_v));
            check("vec_lat", lat, 8);
            check("vec_busy", bcnt, 8);
        end

        // start held high: back-to-back ops, operands changed mid-shift
        @(negedge clk);
        in_a  = 8'h10;
        in_b  = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        in_a = 8'h20;
        in_b = 8'h02;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_lat0", n, 8);
        check("b2b_out0", int'(out), 9'h00F);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) check("b2b_nodbl", int'(done), 0);
        end while (!done && n < 20);
        check("b2b_period", n, 9);
        check("b2b_out1", int'(out), 9'h01E);
        start = 1'b0;
        repeat (2) @(posedge clk);

        // reset mid-shift aborts without a done pulse
        @(negedge clk);
        in_a  = 8'h05;
        in_b  = 8'h03;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_out", int'(out), 0);
        @(negedge clk);
        rst  = 1'b0;
        dcnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) dcnt++;
        end
        check("abort_nodone", dcnt, 0);

        run_op(8'h09, 8'h04, 1'b0, 1'b1, res, lat, bcnt);
        check("late_chg_out", int'(res), 9'h005);
        check("late_chg_lat", lat, 8);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ra, rb, 1'b1, 1'b0, res, lat, bcnt);
            check("rand_out", int'(res), int'(model(ra, rb)));
            check("rand_lat", lat, 8);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: start  input  1  request; sampled only in IDLE or DONE.
REQ-004 SHALL have ports: in_a  input  8  minuend, two's complement; in_b  input  8  subtrahend, two's complement.
REQ-005 SHALL have ports: busy  output  1  high while in SHIFT; done  output  1  one-cycle result-valid pulse.
REQ-006 SHALL have ports: out  output  9  out[7:0] = difference, out[8] = signed overflow flag.
REQ-007 SHALL have parameter: none; width is fixed at 8 through package constant SUB_W, default 8.

Function
REQ-008 SHALL compute in_a - in_b bit-serially, LSB first, as a + ~b + 1: borrow register initialised to "no borrow" (carry-in 1) at operand capture.
REQ-009 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-010 IDLE: start=1 at edge E0 latches in_a/in_b into shift registers, clears bit counter, goes to SHIFT; start=0 stays IDLE.
REQ-011 SHIFT: each edge processes one bit and increments counter 0..7; at the edge processing bit 7 (E8) go to DONE, load out, raise done.
REQ-012 Latency SHALL be exactly 8 edges from start capture to done=1; busy=1 from after E0 until after E8.
REQ-013 DONE: lasts one cycle; start=1 here SHALL be accepted as in IDLE (back-to-back, one done per operation); else return to IDLE.
REQ-014 start in SHIFT SHALL be ignored; in_a/in_b changes after capture SHALL NOT affect the result.
REQ-015 out[7:0] SHALL equal (in_a - in_b) mod 256; out[8] SHALL be 1 iff a[7] != b[7] and result[7] != a[7].
REQ-016 out SHALL hold its value until the next done load or reset; done SHALL never be high two consecutive cycles for one operation.

Reset
REQ-017 rst=1 SHALL immediately force IDLE, busy=0, done=0, out=9'h000, counter and shift registers to 0.
REQ-018 rst asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after release begins a fresh operation.

Configuration
REQ-019 Macro SERIAL_SUBTRACTOR_SATURATE_EN defined: on overflow out[7:0] SHALL be 8'h80 if captured a[7]=1, else 8'h7F; out[8] still 1.
REQ-020 Macro undefined: out[7:0] SHALL be the wrapped difference; timing identical in both builds.

Structure
REQ-021 Shared package SHALL hold SUB_W, the FSM state type/encoding (IDLE, SHIFT, DONE) and the saturation constants 8'h7F/8'h80.
REQ-022 One sub-module SHALL be instantiated: full_subtractor (one-bit a, b, borrow-in -> diff, borrow-out), used once per serial step.

Verification
REQ-023 in_a=0x05, in_b=0x03, start pulse -> done exactly 8 edges later, out=9'h002, busy high 8 cycles.
REQ-024 in_a=0x03, in_b=0x05 -> out=9'h0FE (no overflow); in_a=0x00, in_b=0x00 -> out=9'h000.
REQ-025 in_a=0x80, in_b=0x01 -> out=9'h17F; with SATURATE_EN -> out=9'h180. in_a=0x7F, in_b=0xFF -> out=9'h180; with SATURATE_EN -> 9'h17F.
REQ-026 start held high continuously with operands 0x10-0x01 then 0x20-0x02 -> done pulses every 9 cycles, out=9'h00F then 9'h01E; start during SHIFT ignored.
REQ-027 rst asserted after 4 SHIFT edges -> busy=0, done=0, out=9'h000 immediately; no done until a new start completes 8 edges later.
REQ-028 Operands changed to 0xFF/0xFF one cycle after capture of 0x09/0x04 -> out=9'h005.
